hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 113 +++++++++++
 tb/tb_hazard_scoreboard.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Tracks in-flight register writers for the E..W stages and decides, for the
// instruction sitting in D, whether it must stall or which stage forwards each
// source operand. Also tracks the HI/LO unit so HI/LO readers wait while a
// multiply or divide is running.
//
// Record k describes the instruction in stage k (1=E, 2=M, 3=W). Its tnew is
// the number of cycles left until that instruction's result exists. An operand
// needed in Tuse cycles can be forwarded once tnew <= Tuse. A record with
// tnew==0 holds the value right now, so its stage index is the forward source.
module hazard_scoreboard #(
    parameter int NSTAGE   = 3,
    parameter int TW       = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    localparam int FW      = $clog2(NSTAGE + 1),
    localparam int MD_MAX  = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC,
    localparam int CW      = $clog2(MD_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    d_rs,
    input  logic [4:0]    d_rt,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic [4:0]    d_dst,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_is_md,
    input  logic          d_md_start,
    input  logic          d_md_div,
    output logic          stall,
    output logic [FW-1:0] fwd_rs,
    output logic [FW-1:0] fwd_rt,
    output logic          md_busy
);

    logic          r_valid [1:NSTAGE];
    logic [4:0]    r_dst   [1:NSTAGE];
    logic [TW-1:0] r_tnew  [1:NSTAGE];
    logic [CW-1:0] r_md_cnt;

    logic          w_md_stall;

    // Per-operand lookup: rs is operand 0, rt is operand 1.
    for (genvar op = 0; op < 2; op++) begin : g_op
        logic [4:0]    w_src;
        logic [TW-1:0] w_tuse;
        logic          w_hit;
        logic [FW-1:0] w_idx;
        logic [TW-1:0] w_hit_tnew;
        logic          w_stall;
        logic [FW-1:0] w_fwd;

        assign w_src  = (op == 0) ? d_rs : d_rt;
        assign w_tuse = (op == 0) ? d_tuse_rs : d_tuse_rt;

        // Scan oldest to youngest so the youngest matching record wins.
        always_comb begin
            w_hit      = 1'b0;
            w_idx      = '0;
            w_hit_tnew = '0;
            for (int k = NSTAGE; k >= 1; k--) begin
                if (r_valid[k] && (r_dst[k] == w_src) && (r_dst[k] != 5'd0)
                    && (w_tuse != '1)) begin
                    w_hit      = 1'b1;
                    w_idx      = FW'(k);
                    w_hit_tnew = r_tnew[k];
                end
            end
        end

        assign w_stall = w_hit && (w_hit_tnew > w_tuse);
        assign w_fwd   = (w_hit && (w_hit_tnew == '0)) ? w_idx : '0;
    end

    assign md_busy    = (r_md_cnt != '0);
    assign w_md_stall = d_is_md && md_busy;
    assign stall      = g_op[0].w_stall | g_op[1].w_stall | w_md_stall;
    assign fwd_rs     = g_op[0].w_fwd;
    assign fwd_rt     = g_op[1].w_fwd;

    // Advance the stage records; a stalled D instruction enters E as a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= NSTAGE; k++) begin
                r_valid[k] <= 1'b0;
                r_dst[k]   <= 5'd0;
                r_tnew[k]  <= '0;
            end
        end else begin
            r_valid[1] <= ~stall;
            r_dst[1]   <= d_dst;
            r_tnew[1]  <= d_tnew;
            for (int k = 2; k <= NSTAGE; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_dst[k]   <= r_dst[k-1];
                r_tnew[k]  <= (r_tnew[k-1] != '0) ? (r_tnew[k-1] - TW'(1)) : '0;
            end
        end
    end

    // HI/LO busy counter: an issuing start reloads it, otherwise it drains to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt <= '0;
        end else if (d_md_start && !stall) begin
            r_md_cnt <= d_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: each step drives the D-stage inputs,
// queues the expected outputs, then pops and compares them mid-cycle.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_is_md, d_md_start, d_md_div;
    logic       stall;
    logic [1:0] fwd_rs, fwd_rt;
    logic       md_busy;

    typedef struct packed {
        logic       stall;
        logic [1:0] frs;
        logic [1:0] frt;
        logic       busy;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_vec  = 0;
    int    n_miss = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NSTAGE(3), .TW(2), .MULT_CYC(5), .DIV_CYC(10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_dst      (d_dst),
        .d_tnew     (d_tnew),
        .d_is_md    (d_is_md),
        .d_md_start (d_md_start),
        .d_md_div   (d_md_div),
        .stall      (stall),
        .fwd_rs     (fwd_rs),
        .fwd_rt     (fwd_rt),
        .md_busy    (md_busy)
    );

    task automatic set_d(input logic [4:0] rs, input logic [1:0] trs,
                         input logic [4:0] rt, input logic [1:0] trt,
                         input logic [4:0] dst, input logic [1:0] tnew);
        d_rs = rs; d_tuse_rs = trs; d_rt = rt; d_tuse_rt = trt;
        d_dst = dst; d_tnew = tnew;
    endtask

    task automatic set_md(input logic is_md, input logic start, input logic dv);
        d_is_md = is_md; d_md_start = start; d_md_div = dv;
    endtask

    task automatic nop_in();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
        set_md(1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input logic s, input logic [1:0] frs,
                              input logic [1:0] frt, input logic b,
                              input string tag);
        exp_t  e;
        string t;
        e.stall = s; e.frs = frs; e.frt = frt; e.busy = b;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        n_vec += 4;
        assert (stall === e.stall) else begin
            n_miss++;
            $error("FAIL %s.stall observed=%0b expected=%0b", t, stall, e.stall);
        end
        assert (fwd_rs === e.frs) else begin
            n_miss++;
            $error("FAIL %s.fwd_rs observed=%0d expected=%0d", t, fwd_rs, e.frs);
        end
        assert (fwd_rt === e.frt) else begin
            n_miss++;
            $error("FAIL %s.fwd_rt observed=%0d expected=%0d", t, fwd_rt, e.frt);
        end
        assert (md_busy === e.busy) else begin
            n_miss++;
            $error("FAIL %s.md_busy observed=%0b expected=%0b", t, md_busy, e.busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        nop_in();
        repeat (3) expect_out(1'b0, 2'd0, 2'd0, 1'b0, "flush");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        nop_in();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        expect_out(0, 0, 0, 0, "rst");

        // lw $5 then add reading $5 at Tuse=1: one bubble, no forward yet
        set_d(5'd1, 2'd1, 5'd0, 2'd3, 5'd5, 2'd2);
        expect_out(0, 0, 0, 0, "t1_lw");
        set_d(5'd5, 2'd1, 5'd6, 2'd1, 5'd7, 2'd1);
        expect_out(1, 0, 0, 0, "t1_add_stall");
        expect_out(0, 0, 0, 0, "t1_add_go");
        flush();

        // lw $5 then beq at Tuse=0: two bubbles then forward from W
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd2);
        expect_out(0, 0, 0, 0, "t2_lw");
        set_d(5'd5, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
        expect_out(1, 0, 0, 0, "t2_beq_stall1");
        expect_out(1, 0, 0, 0, "t2_beq_stall2");
        expect_out(0, 3, 0, 0, "t2_beq_fwdw");
        flush();

        // addu $3 then beq at Tuse=0: one bubble then forward from M
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd1);
        expect_out(0, 0, 0, 0, "t3_addu");
        set_d(5'd3, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
        expect_out(1, 0, 0, 0, "t3_beq_stall");
        expect_out(0, 2, 0, 0, "t3_beq_fwdm");
        flush();

        // writes to $0 never create hazards
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2);
        expect_out(0, 0, 0, 0, "t4_prod0");
        set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
        expect_out(0, 0, 0, 0, "t4_cons0_a");
        expect_out(0, 0, 0, 0, "t4_cons0_b");
        flush();

        // youngest writer of $6 wins on the rt port
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd2);
        expect_out(0, 0, 0, 0, "t5_old_lw");
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd0);
        expect_out(0, 0, 0, 0, "t5_young");
        set_d(5'd0, 2'd3, 5'd6, 2'd0, 5'd0, 2'd0);
        expect_out(0, 0, 1, 0, "t5_rt_fwde");
        expect_out(0, 0, 2, 0, "t5_rt_fwdm");
        flush();

        // tnew saturates at 0 down the pipe; Tuse all-ones ignores matches
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd0);
        expect_out(0, 0, 0, 0, "t6_addu8");
        nop_in();
        expect_out(0, 0, 0, 0, "t6_gap");
        set_d(5'd8, 2'd0, 5'd8, 2'd3, 5'd0, 2'd0);
        expect_out(0, 2, 0, 0, "t6_sat_unused");
        flush();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd2);
        expect_out(0, 0, 0, 0, "t6_lw9");
        set_d(5'd9, 2'd3, 5'd9, 2'd3, 5'd0, 2'd0);
        expect_out(0, 0, 0, 0, "t6_unused_both");
        flush();

        // mult then mflo: 5 busy cycles; stalled D must enter E as a bubble
        nop_in();
        set_md(1'b1, 1'b1, 1'b0);
        expect_out(0, 0, 0, 0, "t7_mult");
        set_d(5'd14, 2'd0, 5'd0, 2'd3, 5'd14, 2'd0);
        set_md(1'b1, 1'b0, 1'b0);
        repeat (5) expect_out(1, 0, 0, 1, "t7_mflo_stall");
        expect_out(0, 0, 0, 0, "t7_mflo_go");
        flush();

        // mult then div: div waits 5 cycles, issues, then mflo waits 10
        nop_in();
        set_md(1'b1, 1'b1, 1'b0);
        expect_out(0, 0, 0, 0, "t8_mult");
        set_md(1'b1, 1'b1, 1'b1);
        repeat (5) expect_out(1, 0, 0, 1, "t8_div_stall");
        expect_out(0, 0, 0, 0, "t8_div_go");
        set_md(1'b1, 1'b0, 1'b0);
        repeat (10) expect_out(1, 0, 0, 1, "t8_mflo_stall");
        expect_out(0, 0, 0, 0, "t8_mflo_go");
        flush();

        // a new start reloads over a running countdown
        nop_in();
        set_md(1'b0, 1'b1, 1'b0);
        expect_out(0, 0, 0, 0, "t9_mult");
        nop_in();
        expect_out(0, 0, 0, 1, "t9_count");
        set_md(1'b0, 1'b1, 1'b1);
        expect_out(0, 0, 0, 1, "t9_div_reload");
        nop_in();
        repeat (10) expect_out(0, 0, 0, 1, "t9_busy");
        expect_out(0, 0, 0, 0, "t9_idle");

        // reset with counter at 7 and all records valid
        set_md(1'b0, 1'b1, 1'b1);
        expect_out(0, 0, 0, 0, "t10_div");
        nop_in();
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd20, 2'd2);
        expect_out(0, 0, 0, 1, "t10_lw20");
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd21, 2'd2);
        expect_out(0, 0, 0, 1, "t10_lw21");
        set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd22, 2'd2);
        expect_out(0, 0, 0, 1, "t10_lw22");
        set_d(5'd22, 2'd0, 5'd20, 2'd0, 5'd0, 2'd0);
        set_md(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        expect_out(1, 0, 3, 1, "t10_pre_reset");
        reset = 1'b0;
        expect_out(0, 0, 0, 0, "t10_post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
